ctrl_bm_gen2: RTL

Second-generation Bin_Manager controller. It sequences read-info, load-bin, core run, find-global-backtrack-level, backtrack-across-bin and update-bin to reach global SAT or UNSAT. New in this generation: parametrised widths, a per-phase watchdog, an abort input, error reporting, restart from terminal states and saturating statistics counters. It sits between the top-level solver control and the bin_manager sub-blocks / sat_engine core.

---
 rtl/ctrl_bm_gen2.sv | 281 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ctrl_bm_gen2.sv
// ctrl_bm_gen2: second-generation Bin_Manager controller.
// Sequences read-info, load-bin, core run, find-global-backtrack-level,
// backtrack-across-bin and update-bin until global SAT or UNSAT.
// Adds a per-phase watchdog, abort, error reporting, restart from terminal
// states and saturating statistics counters.
//
// Ports:
//   clk, rst               clock, synchronous active-high reset
//   start_bm_i             start / restart request (level)
//   abort_i                abort request, honoured in busy states
//   timeout_cycles_i       per-phase timeout, 0 disables the watchdog
//   done_bm_o, global_sat_o, global_unsat_o, error_o, err_code_o, busy_o
//                          registered status decodes of the state
//   cur_bin_num_o, request_bin_num_o, cur_lvl_o
//                          current bin / global level
//   start_*_o / done_*_i   one-cycle start pulses and done handshakes of the
//                          rdinfo, load, core, find, bkt and update phases
//   nc_all_i, local_sat_i, cur_lvl_from_core_i, bkt_bin_from_core_i,
//   bkt_lvl_from_find_i, bkt_bin_from_find_i
//                          phase results, valid with their done
//   stat_load_cnt_o, stat_bkt_cnt_o
//                          saturating load / backtrack pulse counts
module ctrl_bm_gen2 #(
  parameter int unsigned WIDTH_BIN_ID = 10,
  parameter int unsigned WIDTH_LVL    = 16,
  parameter int unsigned WIDTH_TMO    = 16,
  parameter int unsigned WIDTH_STAT   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start_bm_i,
  input  logic                    abort_i,
  input  logic [WIDTH_TMO-1:0]    timeout_cycles_i,
  output logic                    done_bm_o,
  output logic                    global_sat_o,
  output logic                    global_unsat_o,
  output logic                    error_o,
  output logic [1:0]              err_code_o,
  output logic                    busy_o,
  output logic [WIDTH_BIN_ID-1:0] cur_bin_num_o,
  output logic [WIDTH_BIN_ID-1:0] request_bin_num_o,
  output logic [WIDTH_LVL-1:0]    cur_lvl_o,
  output logic                    start_rdinfo_o,
  input  logic                    done_rdinfo_i,
  input  logic [WIDTH_BIN_ID-1:0] nc_all_i,
  output logic                    start_load_o,
  input  logic                    done_load_i,
  output logic                    start_core_o,
  input  logic                    done_core_i,
  input  logic                    local_sat_i,
  input  logic [WIDTH_LVL-1:0]    cur_lvl_from_core_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_from_core_i,
  output logic                    start_find_o,
  input  logic                    done_find_i,
  input  logic [WIDTH_LVL-1:0]    bkt_lvl_from_find_i,
  input  logic [WIDTH_BIN_ID-1:0] bkt_bin_from_find_i,
  output logic                    start_bkt_o,
  input  logic                    done_bkt_i,
  output logic                    start_update_o,
  input  logic                    done_update_i,
  output logic [WIDTH_STAT-1:0]   stat_load_cnt_o,
  output logic [WIDTH_STAT-1:0]   stat_bkt_cnt_o
);

  typedef enum logic [3:0] {
    StIdle, StRdInfo, StLoad, StCore, StFind, StBkt, StUpdate, StSat, StUnsat, StError
  } state_e;

  localparam logic [1:0] ErrNone    = 2'd0;
  localparam logic [1:0] ErrTimeout = 2'd1;
  localparam logic [1:0] ErrAbort   = 2'd2;
  localparam logic [1:0] ErrBadBin  = 2'd3;

  state_e                  r_state;
  logic [1:0]              r_err_code;
  logic [WIDTH_BIN_ID-1:0] r_nc_all;
  logic [WIDTH_BIN_ID-1:0] r_next_bin;
  logic [WIDTH_BIN_ID-1:0] r_cur_bin;
  logic [WIDTH_LVL-1:0]    r_cur_lvl;
  logic [WIDTH_TMO-1:0]    r_wdog;
  logic [WIDTH_STAT-1:0]   r_stat_load;
  logic [WIDTH_STAT-1:0]   r_stat_bkt;
  logic r_start_rdinfo, r_start_load, r_start_core, r_start_find, r_start_bkt, r_start_update;
  logic r_done_bm, r_sat, r_unsat, r_error, r_busy;

  state_e                  w_state_nxt;
  logic [1:0]              w_err_nxt;
  logic [WIDTH_BIN_ID-1:0] w_nc_all_nxt;
  logic [WIDTH_BIN_ID-1:0] w_next_bin_nxt;
  logic [WIDTH_BIN_ID-1:0] w_cur_bin_nxt;
  logic [WIDTH_LVL-1:0]    w_lvl_nxt;
  logic                    w_restart;
  logic                    w_done;
  logic                    w_busy_st;
  logic                    w_tmo_hit;
  logic                    w_entry;

  assign w_busy_st = r_state inside {StRdInfo, StLoad, StCore, StFind, StBkt, StUpdate};
  assign w_entry   = (w_state_nxt != r_state);

  // Fires on the cycle whose closing edge brings the counter to the timeout,
  // so ERROR is entered exactly timeout_cycles_i cycles after phase entry.
  assign w_tmo_hit = (timeout_cycles_i != '0) &&
                     (({1'b0, r_wdog} + (WIDTH_TMO + 1)'(1)) >= {1'b0, timeout_cycles_i});

  // A done is only honoured in its own phase and never in the start cycle.
  always_comb begin
    w_done = 1'b0;
    unique case (r_state)
      StRdInfo: w_done = done_rdinfo_i & ~r_start_rdinfo;
      StLoad:   w_done = done_load_i   & ~r_start_load;
      StCore:   w_done = done_core_i   & ~r_start_core;
      StFind:   w_done = done_find_i   & ~r_start_find;
      StBkt:    w_done = done_bkt_i    & ~r_start_bkt;
      StUpdate: w_done = done_update_i & ~r_start_update;
      default:  w_done = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_err_nxt      = r_err_code;
    w_nc_all_nxt   = r_nc_all;
    w_next_bin_nxt = r_next_bin;
    w_cur_bin_nxt  = r_cur_bin;
    w_lvl_nxt      = r_cur_lvl;
    w_restart      = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (start_bm_i) w_state_nxt = StRdInfo;
      end
      StSat, StUnsat, StError: begin
        if (start_bm_i) begin
          w_restart   = 1'b1;
          w_state_nxt = StRdInfo;
          w_err_nxt   = ErrNone;
          w_lvl_nxt   = '0;
        end
      end
      default: begin
        // Busy phases: abort beats done, done beats timeout.
        if (abort_i) begin
          w_state_nxt = StError;
          w_err_nxt   = ErrAbort;
        end else if (w_done) begin
          case (r_state)
            StRdInfo: begin
              w_nc_all_nxt = nc_all_i;
              if (nc_all_i == '0) begin
                w_state_nxt = StSat;
              end else begin
                w_next_bin_nxt = WIDTH_BIN_ID'(1);
                w_cur_bin_nxt  = WIDTH_BIN_ID'(1);
                w_state_nxt    = StLoad;
              end
            end
            StLoad: w_state_nxt = StCore;
            StCore: begin
              if (local_sat_i) begin
                w_lvl_nxt = cur_lvl_from_core_i;
                // Last bin checked first, so cur_bin+1 cannot overflow.
                if (r_cur_bin == r_nc_all) begin
                  w_state_nxt = StSat;
                end else begin
                  w_next_bin_nxt = r_cur_bin + WIDTH_BIN_ID'(1);
                  w_state_nxt    = StUpdate;
                end
              end else if (bkt_bin_from_core_i == '0) begin
                w_state_nxt = StUnsat;
              end else begin
                w_state_nxt = StFind;
              end
            end
            StFind: begin
              w_lvl_nxt = bkt_lvl_from_find_i;
              if ((bkt_bin_from_find_i == '0) || (bkt_bin_from_find_i > r_nc_all)) begin
                w_state_nxt = StError;
                w_err_nxt   = ErrBadBin;
              end else begin
                w_next_bin_nxt = bkt_bin_from_find_i;
                w_state_nxt    = StBkt;
              end
            end
            StBkt: w_state_nxt = StUpdate;
            StUpdate: begin
              w_cur_bin_nxt = r_next_bin;
              w_state_nxt   = StLoad;
            end
            default: ;
          endcase
        end else if (w_tmo_hit) begin
          w_state_nxt = StError;
          w_err_nxt   = ErrTimeout;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= StIdle;
      r_err_code     <= ErrNone;
      r_nc_all       <= '0;
      r_next_bin     <= '0;
      r_cur_bin      <= '0;
      r_cur_lvl      <= '0;
      r_wdog         <= '0;
      r_stat_load    <= '0;
      r_stat_bkt     <= '0;
      r_start_rdinfo <= 1'b0;
      r_start_load   <= 1'b0;
      r_start_core   <= 1'b0;
      r_start_find   <= 1'b0;
      r_start_bkt    <= 1'b0;
      r_start_update <= 1'b0;
      r_done_bm      <= 1'b0;
      r_sat          <= 1'b0;
      r_unsat        <= 1'b0;
      r_error        <= 1'b0;
      r_busy         <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_err_code <= w_err_nxt;
      r_nc_all   <= w_nc_all_nxt;
      r_next_bin <= w_next_bin_nxt;
      r_cur_bin  <= w_cur_bin_nxt;
      r_cur_lvl  <= w_lvl_nxt;

      // Start pulses mark the first cycle of each phase.
      r_start_rdinfo <= w_entry && (w_state_nxt == StRdInfo);
      r_start_load   <= w_entry && (w_state_nxt == StLoad);
      r_start_core   <= w_entry && (w_state_nxt == StCore);
      r_start_find   <= w_entry && (w_state_nxt == StFind);
      r_start_bkt    <= w_entry && (w_state_nxt == StBkt);
      r_start_update <= w_entry && (w_state_nxt == StUpdate);

      r_sat     <= (w_state_nxt == StSat);
      r_unsat   <= (w_state_nxt == StUnsat);
      r_error   <= (w_state_nxt == StError);
      r_done_bm <= w_state_nxt inside {StSat, StUnsat, StError};
      r_busy    <= w_state_nxt inside {StRdInfo, StLoad, StCore, StFind, StBkt, StUpdate};

      if (w_entry) begin
        r_wdog <= '0;
      end else if (w_busy_st && (r_wdog != '1)) begin
        r_wdog <= r_wdog + WIDTH_TMO'(1);
      end

      if (w_restart) begin
        r_stat_load <= '0;
        r_stat_bkt  <= '0;
      end else begin
        if (w_entry && (w_state_nxt == StLoad) && (r_stat_load != '1)) begin
          r_stat_load <= r_stat_load + WIDTH_STAT'(1);
        end
        if (w_entry && (w_state_nxt == StBkt) && (r_stat_bkt != '1)) begin
          r_stat_bkt <= r_stat_bkt + WIDTH_STAT'(1);
        end
      end
    end
  end

  assign done_bm_o         = r_done_bm;
  assign global_sat_o      = r_sat;
  assign global_unsat_o    = r_unsat;
  assign error_o           = r_error;
  assign err_code_o        = r_err_code;
  assign busy_o            = r_busy;
  assign cur_bin_num_o     = r_cur_bin;
  assign request_bin_num_o = r_cur_bin;
  assign cur_lvl_o         = r_cur_lvl;
  assign start_rdinfo_o    = r_start_rdinfo;
  assign start_load_o      = r_start_load;
  assign start_core_o      = r_start_core;
  assign start_find_o      = r_start_find;
  assign start_bkt_o       = r_start_bkt;
  assign start_update_o    = r_start_update;
  assign stat_load_cnt_o   = r_stat_load;
  assign stat_bkt_cnt_o    = r_stat_bkt;

endmodule
